// File: rtl/gray_tracker_pkg.sv
// rtl/gray_tracker_pkg.sv - shared types, constants and Gray decode helper for the Gray-code tracker
package gray_tracker_pkg;

    localparam int POS_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Decode a Gray word of up to POS_W bits; narrower words are zero-extended by the caller.
    function automatic logic [POS_W-1:0] gray_decode(input logic [POS_W-1:0] g);
        logic [POS_W-1:0] b;
        b[POS_W-1] = g[POS_W-1];
        for (int i = POS_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_tracker_gray_to_bin.sv
// rtl/gray_tracker_gray_to_bin.sv - combinational reflected-binary Gray to binary decoder
module gray_to_bin
    import gray_tracker_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    input  logic             unused_tie,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it, built from the MSB down.
    always_comb begin
        bin = '0;
        bin[WIDTH-1] = gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

    logic unused_sink;
    assign unused_sink = unused_tie;

endmodule

// File: rtl/gray_tracker.sv
// rtl/gray_tracker.sv - Gray-coded position receiver with step classification and signed position count
module gray_tracker
    import gray_tracker_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Valid,
    input  logic [WIDTH-1:0] GrayIn,
    input  logic             ClrErr,
    output logic [WIDTH-1:0] BinOut,
    output logic             Step,
    output logic             Dir,
    output logic             Wrap,
    output logic [POS_W-1:0] Position,
    output logic             Overflow,
    output logic             Error
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] new_bin;
    logic [WIDTH-1:0] delta;

    gray_to_bin #(.WIDTH(WIDTH)) u_decode (
        .gray       (GrayIn),
        .unused_tie (1'b0),
        .bin        (new_bin)
    );

    // The stored baseline doubles as BinOut, so the step distance is measured against it.
    assign delta = new_bin - bin_q;

    // Next-state, position and flag logic; ClrErr outranks Valid and drops a coincident sample.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        pos_d   = pos_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        if (ClrErr) begin
            err_d   = 1'b0;
            ovf_d   = 1'b0;
            state_d = IDLE;
        end else if (Valid) begin
            case (state_q)
                IDLE: begin
                    bin_d   = new_bin;
                    state_d = TRACK;
                end
                TRACK: begin
                    if (delta == '0) begin
                        bin_d = bin_q;
                    end else if (delta == WIDTH'(1)) begin
                        bin_d  = new_bin;
                        step_d = 1'b1;
                        dir_d  = 1'b1;
                        wrap_d = (bin_q == {WIDTH{1'b1}});
                        pos_d  = pos_q + 1'b1;
                        if (pos_q == 16'h7FFF) ovf_d = 1'b1;
                    end else if (delta == {WIDTH{1'b1}}) begin
                        bin_d  = new_bin;
                        step_d = 1'b1;
                        dir_d  = 1'b0;
                        wrap_d = (bin_q == '0);
                        pos_d  = pos_q - 1'b1;
                        if (pos_q == 16'h8000) ovf_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = FAULT;
                    end
                end
                default: begin
                    state_d = FAULT;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            wrap_q  <= 1'b0;
            pos_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            pos_q   <= pos_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign BinOut   = bin_q;
    assign Step     = step_q;
    assign Dir      = dir_q;
    assign Wrap     = wrap_q;
    assign Position = pos_q;
    assign Overflow = ovf_q;
    assign Error    = err_q;

endmodule

// File: tb/tb_gray_tracker.sv
// tb/tb_gray_tracker.sv - directed self-checking bench for gray_tracker
module tb_gray_tracker;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Valid = 1'b0;
    logic [2:0]  GrayIn = 3'd0;
    logic        ClrErr = 1'b0;
    logic [2:0]  BinOut;
    logic        Step;
    logic        Dir;
    logic        Wrap;
    logic [15:0] Position;
    logic        Overflow;
    logic        Error;

    int checks = 0;
    int failures = 0;

    // Gray code of binary 0..7, written out by hand.
    logic [2:0] gtab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    gray_tracker #(.WIDTH(3)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Valid    (Valid),
        .GrayIn   (GrayIn),
        .ClrErr   (ClrErr),
        .BinOut   (BinOut),
        .Step     (Step),
        .Dir      (Dir),
        .Wrap     (Wrap),
        .Position (Position),
        .Overflow (Overflow),
        .Error    (Error)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [2:0] g, input logic c);
        Reset  = r;
        Valid  = v;
        GrayIn = g;
        ClrErr = c;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bin"}, 32'(BinOut), 0);
        chk({tag, "_step"}, 32'(Step), 0);
        chk({tag, "_dir"}, 32'(Dir), 0);
        chk({tag, "_wrap"}, 32'(Wrap), 0);
        chk({tag, "_pos"}, 32'(Position), 0);
        chk({tag, "_ovf"}, 32'(Overflow), 0);
        chk({tag, "_err"}, 32'(Error), 0);
    endtask

    initial begin
        // Reset state
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk_all_zero("reset");

        // Baseline plus full up-count 0..7..0
        cyc(0, 1, 3'b000, 0);
        chk("up_base_step", 32'(Step), 0);
        chk("up_base_bin", 32'(BinOut), 0);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, gtab[i % 8], 0);
            chk($sformatf("up%0d_step", i), 32'(Step), 1);
            chk($sformatf("up%0d_dir", i), 32'(Dir), 1);
            chk($sformatf("up%0d_wrap", i), 32'(Wrap), (i == 8) ? 1 : 0);
            chk($sformatf("up%0d_pos", i), 32'(Position), i);
            chk($sformatf("up%0d_bin", i), 32'(BinOut), i % 8);
        end
        cyc(0, 0, 3'b000, 0);
        chk("up_after_step", 32'(Step), 0);
        chk("up_after_wrap", 32'(Wrap), 0);

        // Down-count through zero
        cyc(1, 0, 0, 0);
        cyc(0, 1, 3'b000, 0);
        cyc(0, 1, 3'b100, 0);
        chk("dn1_step", 32'(Step), 1);
        chk("dn1_dir", 32'(Dir), 0);
        chk("dn1_wrap", 32'(Wrap), 1);
        chk("dn1_pos", 32'(Position), 32'hFFFF);
        chk("dn1_bin", 32'(BinOut), 7);
        cyc(0, 1, 3'b101, 0);
        chk("dn2_step", 32'(Step), 1);
        chk("dn2_wrap", 32'(Wrap), 0);
        chk("dn2_pos", 32'(Position), 32'hFFFE);
        chk("dn2_bin", 32'(BinOut), 6);

        // Gaps and holds
        cyc(0, 0, 3'b000, 0);
        chk("gap_step", 32'(Step), 0);
        chk("gap_pos", 32'(Position), 32'hFFFE);
        chk("gap_bin", 32'(BinOut), 6);
        cyc(0, 1, 3'b101, 0);
        chk("hold_step", 32'(Step), 0);
        chk("hold_pos", 32'(Position), 32'hFFFE);
        chk("hold_dir", 32'(Dir), 0);
        cyc(0, 0, 3'b111, 0);
        cyc(0, 1, 3'b101, 0);
        chk("hold2_step", 32'(Step), 0);
        chk("hold2_wrap", 32'(Wrap), 0);
        chk("hold2_pos", 32'(Position), 32'hFFFE);

        // Illegal jump 1 -> 6
        cyc(1, 0, 0, 0);
        cyc(0, 1, 3'b001, 0);
        chk("ill_base_bin", 32'(BinOut), 1);
        cyc(0, 1, 3'b101, 0);
        chk("ill_err", 32'(Error), 1);
        chk("ill_step", 32'(Step), 0);
        chk("ill_bin", 32'(BinOut), 1);
        chk("ill_pos", 32'(Position), 0);
        cyc(0, 1, 3'b000, 0);
        chk("fault_ign_step", 32'(Step), 0);
        chk("fault_ign_bin", 32'(BinOut), 1);
        chk("fault_ign_pos", 32'(Position), 0);
        chk("fault_err_sticky", 32'(Error), 1);
        cyc(0, 0, 3'b000, 1);
        chk("clr_err", 32'(Error), 0);
        chk("clr_bin_kept", 32'(BinOut), 1);
        cyc(0, 1, 3'b011, 0);
        chk("post_clr_base_step", 32'(Step), 0);
        chk("post_clr_base_bin", 32'(BinOut), 2);
        chk("post_clr_base_pos", 32'(Position), 0);
        cyc(0, 1, 3'b010, 0);
        chk("post_clr_up_step", 32'(Step), 1);
        chk("post_clr_up_pos", 32'(Position), 1);
        chk("post_clr_up_bin", 32'(BinOut), 3);

        // ClrErr with Valid drops the sample, then the next sample is baseline only
        cyc(0, 1, 3'b110, 1);
        chk("clrv_step", 32'(Step), 0);
        chk("clrv_bin", 32'(BinOut), 3);
        chk("clrv_pos", 32'(Position), 1);
        chk("clrv_dir", 32'(Dir), 1);
        cyc(0, 1, 3'b110, 0);
        chk("clrv_base_step", 32'(Step), 0);
        chk("clrv_base_bin", 32'(BinOut), 4);
        chk("clrv_base_pos", 32'(Position), 1);

        // Reset together with ClrErr and Valid
        cyc(1, 1, 3'b111, 1);
        chk_all_zero("rst_clr");

        // Reset mid-stream discards the baseline
        cyc(0, 1, 3'b000, 0);
        cyc(0, 1, 3'b001, 0);
        chk("mid_pre_pos", 32'(Position), 1);
        cyc(1, 1, 3'b011, 0);
        chk_all_zero("mid_rst");
        cyc(0, 1, 3'b011, 0);
        chk("mid_base_step", 32'(Step), 0);
        chk("mid_base_bin", 32'(BinOut), 2);
        chk("mid_base_pos", 32'(Position), 0);

        // Overflow via 32767 up-steps, then one more
        cyc(1, 0, 0, 0);
        cyc(0, 1, 3'b000, 0);
        for (int k = 1; k <= 32767; k++) begin
            cyc(0, 1, gtab[k % 8], 0);
        end
        chk("ovf_pre_pos", 32'(Position), 32'h7FFF);
        chk("ovf_pre_flag", 32'(Overflow), 0);
        cyc(0, 1, gtab[0], 0);
        chk("ovf_pos", 32'(Position), 32'h8000);
        chk("ovf_flag", 32'(Overflow), 1);
        chk("ovf_wrap", 32'(Wrap), 1);
        cyc(0, 0, 3'b000, 0);
        chk("ovf_sticky", 32'(Overflow), 1);
        cyc(0, 1, 3'b001, 0);
        chk("ovf_sticky2", 32'(Overflow), 1);
        chk("ovf_pos2", 32'(Position), 32'h8001);
        cyc(0, 1, 3'b000, 0);
        chk("ovf_pos3", 32'(Position), 32'h8000);
        cyc(0, 0, 3'b000, 1);
        chk("ovf_clr_flag", 32'(Overflow), 0);
        chk("ovf_clr_pos", 32'(Position), 32'h8000);
        cyc(0, 1, 3'b000, 0);
        cyc(0, 1, 3'b100, 0);
        chk("ovf_dn_pos", 32'(Position), 32'h7FFF);
        chk("ovf_dn_flag", 32'(Overflow), 1);
        chk("ovf_dn_dir", 32'(Dir), 0);
        chk("ovf_dn_wrap", 32'(Wrap), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_tracker.md
# gray_tracker

Receive-side companion to the free-running Gray-code counter. Samples a WIDTH-bit Gray-coded position word each cycle it is qualified by `Valid`, decodes it to binary, and classifies each new sample relative to the previous one as hold, up-step, down-step or illegal jump. It keeps a signed 16-bit running position and flags wrap-around, position overflow and protocol errors. It sits at the consuming end of any Gray-coded count link, such as a counter output crossing into another block or a position encoder.

## Interface
- `WIDTH`, default 3: Gray word width; legal range 2..16.
- `Clk`, input, 1: rising-edge clock.
- `Reset`, input, 1: synchronous, active-high; clears all state and outputs.
- `Valid`, input, 1: `GrayIn` is sampled this cycle.
- `GrayIn`, input, WIDTH: reflected-binary Gray code word.
- `ClrErr`, input, 1: synchronous clear of the FAULT state and of the sticky flags.
- `BinOut`, output, WIDTH: binary decode of the last accepted sample; registered.
- `Step`, output, 1: one-cycle pulse for each legal ±1 step.
- `Dir`, output, 1: direction of the last step; 1 = up, 0 = down; holds its value between steps.
- `Wrap`, output, 1: one-cycle pulse on a step max→0 (up) or 0→max (down).
- `Position`, output, 16: signed two's-complement step count.
- `Overflow`, output, 1: sticky; set when `Position` wraps 0x7FFF→0x8000 or 0x8000→0x7FFF.
- `Error`, output, 1: sticky; set on an illegal jump.

## Operation
- Decode: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i].
- Let `prev` be the stored binary value and `new` the decode of `GrayIn`. Then d = (new − prev) mod 2^WIDTH.
- Legality is judged only on d. A single-bit Gray change that is not ±1 in binary is illegal. Example for WIDTH=3: 001→101 (1→6) is illegal.
- States:
  - IDLE: no baseline held.
  - TRACK: baseline held.
  - FAULT: an illegal jump was seen.
- IDLE with `Valid`:
  - Load `prev` = `new` and set `BinOut` = `new`.
  - Go to TRACK. No `Step` is issued.
- TRACK with `Valid`:
  - d = 0: hold. No pulse, `Position` unchanged.
  - d = 1: `Step`=1, `Dir`=1, `Position`+1. `Wrap`=1 if prev = 2^WIDTH−1.
  - d = 2^WIDTH−1: `Step`=1, `Dir`=0, `Position`−1. `Wrap`=1 if prev = 0.
  - Any other d: `Error`=1, go to FAULT. `prev`, `BinOut` and `Position` are not updated.
- FAULT: `Valid` is ignored. Only `ClrErr` or `Reset` leaves this state.
- `ClrErr` (any state):
  - Clears `Error` and `Overflow`, goes to IDLE.
  - `Position`, `Dir` and `BinOut` are retained.
  - A `Valid` sample in the same cycle is dropped.
- `Position` arithmetic is 16-bit modulo. `Overflow` is set on the signed wrap and stays set until `ClrErr` or `Reset`.
- Without `Valid`, no state changes and no pulses occur.

## Timing
- All outputs are registered. A sample accepted at edge N is reflected on `BinOut`, `Step`, `Dir`, `Wrap`, `Position`, `Overflow` and `Error` after edge N, i.e. one cycle of latency.
- `Step` and `Wrap` are high for exactly one cycle per accepted step. Back-to-back steps on consecutive cycles give consecutive pulses.
- Full throughput: one sample per cycle, no backpressure.
- Priority: `Reset` > `ClrErr` > `Valid`.
- Reset values: state IDLE, `BinOut`=0, `Step`=0, `Dir`=0, `Wrap`=0, `Position`=0, `Overflow`=0, `Error`=0.
- Reset asserted mid-stream discards the baseline. The first sample after reset is baseline-only and produces no `Step`.

## Structure
- Shared package holds:
  - the state enum (IDLE, TRACK, FAULT);
  - the `POS_W`=16 constant;
  - a gray-to-binary function, reusable by the counter side for self-check.
- One sub-module is natural: `gray_to_bin`, purely combinational, parameterised by WIDTH. The top level holds the FSM, the `prev` register and the position/flag logic.

## Test plan
- Baseline plus up-count: after reset, feed Gray 000,001,011,010,110,111,101,100,000 with `Valid`=1.
  - First sample gives no `Step`.
  - Then 8 `Step` pulses with `Dir`=1.
  - `Wrap` pulses once, on 100→000.
  - `Position`=8, `BinOut`=0.
- Down-count through zero: baseline 000, then 100 (7), 101 (6).
  - Two `Step` pulses with `Dir`=0.
  - `Wrap` on 0→7.
  - `Position`=0xFFFE.
- Illegal jump: baseline 001, then 101.
  - `Error`=1, no `Step`, `BinOut` stays 1.
  - Later `Valid` samples are ignored.
  - `ClrErr` gives `Error`=0 and state IDLE; the next sample is baseline-only.
- Hold and gaps: repeat the same Gray word, and interleave `Valid`=0 cycles.
  - No pulses; `Position` unchanged.
- Overflow: force `Position` to 0x7FFF via 32767 up-steps, then one more up-step.
  - `Position`=0x8000, `Overflow`=1 and stays set.
  - `ClrErr` clears `Overflow` and keeps `Position`.
- Reset and priority:
  - `Reset` mid-stream clears all outputs to 0 and forces IDLE.
  - `ClrErr` together with `Valid` drops the sample.
  - `Reset` together with `ClrErr` gives reset values.
